seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are 8 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only when busy is low.
REQ-005 The block SHALL have port alusel, input, 3 bits: opcode 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 mul, 110 divu, 111 reserved.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-007 The block SHALL have port c, output, WIDTH bits: the registered primary result (low product word for mul, quotient for divu).
REQ-008 The block SHALL have port hi, output, WIDTH bits: the registered secondary result (high product word for mul, remainder for divu, 0 for other ops).
REQ-009 The block SHALL have port z, output, 1 bit: registered flag, high when c == 0.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an iterative operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking that c, hi and z are valid.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE; busy SHALL be high only in CALC, and done SHALL be high only in DONE.
REQ-013 Start accept: when start is high in IDLE or DONE, the block SHALL capture a, b and alusel on that rising edge; start in CALC SHALL be ignored.
REQ-014 Single-cycle ops (000-100, 111): the FSM SHALL go directly to DONE, with done high and results valid in the cycle after the accepting edge (latency 1).
REQ-015 add/sub/and/or SHALL be computed modulo 2^WIDTH, and slt SHALL give c = 1 if a < b (unsigned comparison), else 0.
REQ-016 Every single-cycle op SHALL set hi = 0.
REQ-017 Reserved op 111 SHALL give c = 0, hi = 0 and z = 1.
REQ-018 mul SHALL be unsigned shift-add, one bit per cycle, for exactly WIDTH cycles in CALC; the 2*WIDTH-bit product SHALL appear as {hi, c}; done SHALL rise WIDTH+1 cycles after the accepting edge.
REQ-019 divu SHALL be unsigned restoring division, one bit per cycle, for exactly WIDTH cycles in CALC; c SHALL be the quotient and hi the remainder; latency SHALL equal that of mul.
REQ-020 For divu by zero, the block SHALL return c = all ones and hi = a, with no error flag.
REQ-021 An internal iteration counter of ceil(log2(WIDTH))+1 bits SHALL count from 0 to WIDTH-1, and CALC SHALL exit to DONE when the counter equals WIDTH-1.
REQ-022 c, hi and z SHALL hold their last values through IDLE and CALC, changing only on entry to DONE.
REQ-023 When DONE is reached with start low, the FSM SHALL return to IDLE; when start is high in DONE, the new op SHALL be accepted (back-to-back, no idle gap).
REQ-024 Operand changes on a/b/alusel after the accepting edge SHALL have no effect on the op in flight.

Reset
REQ-025 While rst is low, the block SHALL hold state = IDLE, c = 0, hi = 0, z = 1, busy = 0, done = 0, and the counter and operand registers at 0.
REQ-026 Assertion of rst during CALC SHALL abort the op immediately with no done pulse, and the first start after rst rises SHALL be accepted normally.

Configuration
REQ-027 The macro SEQ_ALU_DIV_EN SHALL control the divider datapath: defined means divu is implemented per REQ-019/020; undefined means no divider logic is compiled in and op 110 behaves exactly as reserved op 111 (latency 1, c = 0, hi = 0, z = 1).

Verification (WIDTH=32)
REQ-028 Bench SHALL apply add with a=32'hFFFFFFFF, b=1 and require done after 1 cycle with c=0, z=1, hi=0, busy never high.
REQ-029 Bench SHALL apply mul with a=32'h12345678, b=32'h9ABCDEF0 and require busy for 32 cycles, done at cycle 33, and {hi,c}=64'h0B00EA4E_242D2080.
REQ-030 Bench SHALL apply divu with a=100, b=7 (macro defined) and require c=14, hi=2 at cycle 33; then divu with a=5, b=0 and require c=32'hFFFFFFFF, hi=5.
REQ-031 Bench SHALL assert start with a new add in the DONE cycle of a mul and require the add to complete 1 cycle later, with start pulses during CALC having no effect.
REQ-032 Bench SHALL drive rst low at cycle 10 of a mul and require outputs at reset values with no done pulse, then a slt with a=3, b=5 giving c=1 after release.
REQ-033 Bench SHALL run a build with SEQ_ALU_DIV_EN undefined and require divu with a=100, b=7 to give done after 1 cycle with c=0, hi=0, z=1.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle add/sub/and/or/slt and iterative
// shift-add multiply and restoring divide (one result bit per clock).
// Build option: define SEQ_ALU_DIV_EN to compile in the divider datapath;
// without it, opcode 110 is handled exactly like the reserved opcode 111.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alusel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] hi,
    output logic             z,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [2:0] OP_DIVU = 3'b110;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q;        // multiplicand
`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH-1:0]   b_q;        // divisor
    logic [2:0]         op_q;       // opcode of the op in flight
`endif
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_q;      // product high word / partial remainder
    logic [WIDTH-1:0]   sh_q;       // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0]   c_q, hi_q;
    logic               z_q;

    logic               accept;
    logic               iter_op;
    logic               last_iter;
    logic [WIDTH-1:0]   sc_res;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   iter_hi, iter_lo;
`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
`endif

    // Request decode, single-cycle result and one multiply/divide step.
    always_comb begin
        accept    = start && (state_q != CALC);
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef SEQ_ALU_DIV_EN
        iter_op   = (alusel == OP_MUL) || (alusel == OP_DIVU);
`else
        iter_op   = (alusel == OP_MUL);
`endif
        sc_res = '0;
        case (alusel)
            OP_ADD:  sc_res = a + b;
            OP_SUB:  sc_res = a - b;
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_SLT:  sc_res = (a < b) ? WIDTH'(1) : '0;
            default: sc_res = '0;
        endcase

        // Shift-add: add multiplicand when the multiplier LSB is set, then
        // shift the {acc, multiplier} pair right by one.
        mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, a_q} : '0);
        iter_hi = mul_sum[WIDTH:1];
        iter_lo = {mul_sum[0], sh_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        // Restoring step: bring in the next dividend bit and subtract when it
        // fits. A zero divisor always "fits", which naturally yields an
        // all-ones quotient and leaves the dividend as the remainder.
        div_shift = {acc_q, sh_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = (div_shift >= {1'b0, b_q});
        if (op_q == OP_DIVU) begin
            iter_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            iter_lo = {sh_q[WIDTH-2:0], div_ge};
        end
`endif
    end

    // Next-state logic: single-cycle ops go straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = iter_op ? CALC : DONE;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    state_d = start ? (iter_op ? CALC : DONE) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
`ifdef SEQ_ALU_DIV_EN
            b_q   <= '0;
            op_q  <= '0;
`endif
            cnt_q <= '0;
            acc_q <= '0;
            sh_q  <= '0;
            c_q   <= '0;
            hi_q  <= '0;
            z_q   <= 1'b1;
        end else if (accept) begin
            a_q   <= a;
`ifdef SEQ_ALU_DIV_EN
            b_q   <= b;
            op_q  <= alusel;
`endif
            cnt_q <= '0;
            acc_q <= '0;
            sh_q  <= (alusel == OP_MUL) ? b : a;
            if (!iter_op) begin
                c_q  <= sc_res;
                hi_q <= '0;
                z_q  <= (sc_res == '0);
            end
        end else if (state_q == CALC) begin
            acc_q <= iter_hi;
            sh_q  <= iter_lo;
            cnt_q <= last_iter ? cnt_q : cnt_q + 1'b1;
            if (last_iter) begin
                c_q  <= iter_lo;
                hi_q <= iter_hi;
                z_q  <= (iter_lo == '0);
            end
        end
    end

    assign c    = c_q;
    assign hi   = hi_q;
    assign z    = z_q;
    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed test of seq_alu at WIDTH=32. Divide expectations follow
// the SEQ_ALU_DIV_EN build option.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   alusel;
    logic [W-1:0] a, b;
    logic [W-1:0] c, hi;
    logic         z, busy, done;

    int checks = 0;
    int errors = 0;
    int lat, bc;

    seq_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .alusel (alusel),
        .a      (a),
        .b      (b),
        .c      (c),
        .hi     (hi),
        .z      (z),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble operands after acceptance, and wait for done.
    // lat = sample index (1 = first cycle after accept) where done was seen.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat_o, output int bc_o);
        start  = 1'b1;
        alusel = op;
        a      = x;
        b      = y;
        tick();
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        alusel = 3'($urandom);
        lat_o  = 0;
        bc_o   = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat_o = k;
                break;
            end
            if (busy) bc_o++;
            tick();
        end
        $display("op=%b a=%h b=%h -> c=%h hi=%h z=%b latency=%0d busy_cycles=%0d",
                 op, x, y, c, hi, z, lat_o, bc_o);
    endtask

    initial begin
        logic [W-1:0] prev_c, prev_hi;

        rst = 1'b0; start = 1'b0; alusel = '0; a = '0; b = '0;
        repeat (3) tick();
        check("rst_c", 64'(c), 64'h0);
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_z", 64'(z), 64'h1);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        rst = 1'b1;
        tick();

        // add wraps to zero
        run_op(3'b000, 32'hFFFF_FFFF, 32'h1, lat, bc);
        check("add_lat", 64'(lat), 64'd1);
        check("add_busy", 64'(bc), 64'd0);
        check("add_c", 64'(c), 64'h0);
        check("add_z", 64'(z), 64'h1);
        check("add_hi", 64'(hi), 64'h0);
        tick();
        check("add_idle_done", 64'(done), 64'h0);
        check("add_hold_z", 64'(z), 64'h1);

        run_op(3'b001, 32'd5, 32'd7, lat, bc);
        check("sub_c", 64'(c), 64'hFFFF_FFFE);
        check("sub_z", 64'(z), 64'h0);
        run_op(3'b010, 32'hF0F0_F0F0, 32'h3C3C_3C3C, lat, bc);
        check("and_c", 64'(c), 64'h3030_3030);
        run_op(3'b011, 32'hF0F0_F0F0, 32'h0F0F_0000, lat, bc);
        check("or_c", 64'(c), 64'hFFFF_F0F0);
        run_op(3'b100, 32'd5, 32'd3, lat, bc);
        check("slt_false_c", 64'(c), 64'h0);
        check("slt_false_z", 64'(z), 64'h1);
        run_op(3'b100, 32'h0000_0001, 32'h8000_0000, lat, bc);
        check("slt_unsigned_c", 64'(c), 64'h1);
        run_op(3'b111, 32'd7, 32'd9, lat, bc);
        check("rsv_lat", 64'(lat), 64'd1);
        check("rsv_c", 64'(c), 64'h0);
        check("rsv_hi", 64'(hi), 64'h0);
        check("rsv_z", 64'(z), 64'h1);

        // multiply
        run_op(3'b101, 32'h1234_5678, 32'h9ABC_DEF0, lat, bc);
        check("mul_lat", 64'(lat), 64'd33);
        check("mul_busy", 64'(bc), 64'd32);
        check("mul_prod", {hi, c}, 64'h0B00_EA4E_242D_2080);
        check("mul_z", 64'(z), 64'h0);

        // divide (or reserved behaviour when the divider is not built)
`ifdef SEQ_ALU_DIV_EN
        run_op(3'b110, 32'd100, 32'd7, lat, bc);
        check("div_lat", 64'(lat), 64'd33);
        check("div_busy", 64'(bc), 64'd32);
        check("div_q", 64'(c), 64'd14);
        check("div_r", 64'(hi), 64'd2);
        run_op(3'b110, 32'd5, 32'd0, lat, bc);
        check("div0_lat", 64'(lat), 64'd33);
        check("div0_q", 64'(c), 64'hFFFF_FFFF);
        check("div0_r", 64'(hi), 64'd5);
        prev_c  = 32'hFFFF_FFFF;
        prev_hi = 32'd5;
`else
        run_op(3'b110, 32'd100, 32'd7, lat, bc);
        check("nodiv_lat", 64'(lat), 64'd1);
        check("nodiv_busy", 64'(bc), 64'd0);
        check("nodiv_c", 64'(c), 64'h0);
        check("nodiv_hi", 64'(hi), 64'h0);
        check("nodiv_z", 64'(z), 64'h1);
        prev_c  = '0;
        prev_hi = '0;
`endif
        tick();

        // mul with ignored starts during CALC, then back-to-back add in DONE
        start = 1'b1; alusel = 3'b101; a = 32'd3; b = 32'd5;
        tick();
        start = 1'b0; a = $urandom; b = $urandom;
        check("calc_busy", 64'(busy), 64'h1);
        check("calc_hold_c", 64'(c), 64'(prev_c));
        check("calc_hold_hi", 64'(hi), 64'(prev_hi));
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (k == 5 || k == 20) begin
                start = 1'b1; alusel = 3'b000; a = 32'd1; b = 32'd1;
            end
            tick();
        end
        $display("mul 3*5 with start pulses in CALC -> c=%h hi=%h latency=%0d", c, hi, lat);
        check("b2b_mul_lat", 64'(lat), 64'd33);
        check("b2b_mul_c", 64'(c), 64'd15);
        check("b2b_mul_hi", 64'(hi), 64'd0);
        start = 1'b1; alusel = 3'b000; a = 32'd10; b = 32'd20;
        tick();
        start = 1'b0;
        $display("back-to-back add 10+20 -> done=%b c=%h", done, c);
        check("b2b_add_done", 64'(done), 64'h1);
        check("b2b_add_busy", 64'(busy), 64'h0);
        check("b2b_add_c", 64'(c), 64'd30);
        tick();
        check("b2b_idle", 64'(done), 64'h0);

        // reset asserted in the middle of a multiply
        start = 1'b1; alusel = 3'b101; a = 32'hFFFF; b = 32'hFFFF;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("abort_busy_before", 64'(busy), 64'h1);
        rst = 1'b0;
        #1;
        $display("reset during mul -> c=%h hi=%h z=%b busy=%b done=%b", c, hi, z, busy, done);
        check("abort_c", 64'(c), 64'h0);
        check("abort_hi", 64'(hi), 64'h0);
        check("abort_z", 64'(z), 64'h1);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_done", 64'(done), 64'h0);
        repeat (2) begin
            tick();
            check("abort_no_done", 64'(done), 64'h0);
        end
        rst = 1'b1;
        repeat (3) begin
            tick();
            check("abort_no_done_after", 64'(done), 64'h0);
        end
        run_op(3'b100, 32'd3, 32'd5, lat, bc);
        check("post_rst_slt_lat", 64'(lat), 64'd1);
        check("post_rst_slt_c", 64'(c), 64'h1);
        check("post_rst_slt_hi", 64'(hi), 64'h0);
        check("post_rst_slt_z", 64'(z), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
